deadlock_block_detector: RTL and testbench

DEADLOCK_BLOCK_DETECTOR -- requirements
Module: deadlock_block_detector

---
 rtl/deadlock_block_detector.sv | 125 ++++++++++++
 tb/tb_deadlock_block_detector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/deadlock_block_detector.sv
// deadlock_block_detector
//   Flags a kernel deadlock. It fires when every active instance has been
//   stalled on a FIFO or ap_continue for THRESH consecutive cycles and no
//   AXI-stream port is stalled on the testbench.
// Ports:
//   clock            - single clock; all state changes on its rising edge
//   reset            - synchronous, active-high
//   axis_block_sigs  - [N_AXIS] per-port testbench stall; any bit vetoes detection
//   inst_idle_sigs   - [N_IDLE] ap_idle; low N_INST bits are instances, rest informational
//   inst_block_sigs  - [N_INST] per-instance stall
//   block            - high exactly while in BLOCKED
//   block_mask       - stuck set captured on the latest entry into BLOCKED
//   block_count      - saturating count of entries into BLOCKED
module deadlock_block_detector #(
  parameter int unsigned N_AXIS = 2,
  parameter int unsigned N_IDLE = 10,
  parameter int unsigned N_INST = 5,
  parameter int unsigned THRESH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_IDLE-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block,
  output logic [N_INST-1:0] block_mask,
  output logic [15:0]       block_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WATCH   = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  localparam logic [16:0] THRESH_W = 17'(THRESH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_cnt;
  logic [15:0]       w_cnt_nxt;
  logic [16:0]       w_cnt_inc;
  logic              w_enter;
  logic [N_INST-1:0] w_active;
  logic [N_INST-1:0] w_stuck;
  logic              w_cand;

  // Sub-instance idle bits carry no meaning for detection.
  generate
    if (N_IDLE > N_INST) begin : g_sub_idle
      logic w_unused_sub_idle;
      assign w_unused_sub_idle = |inst_idle_sigs[N_IDLE-1:N_INST];
    end
  endgenerate

  assign w_active  = ~inst_idle_sigs[N_INST-1:0];
  assign w_stuck   = w_active & inst_block_sigs;
  // Any testbench-side stall means the kernel is waiting on the outside world.
  assign w_cand    = (w_active != '0) && (w_active == w_stuck) && (axis_block_sigs == '0);
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enter     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cand) begin
          w_cnt_nxt = 16'd1;
          if (THRESH == 1) begin
            w_state_nxt = S_BLOCKED;
            w_enter     = 1'b1;
          end else begin
            w_state_nxt = S_WATCH;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_WATCH: begin
        if (w_cand) begin
          w_cnt_nxt = w_cnt_inc[15:0];
          if (w_cnt_inc == THRESH_W) begin
            w_state_nxt = S_BLOCKED;
            w_enter     = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_BLOCKED: begin
        if (!w_cand) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      block       <= 1'b0;
      block_mask  <= '0;
      block_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      block   <= (w_state_nxt == S_BLOCKED);
      if (w_enter) begin
        block_mask <= w_stuck;
        if (block_count != 16'hFFFF) begin
          block_count <= block_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_deadlock_block_detector.sv
// tb_deadlock_block_detector
//   Directed bench for deadlock_block_detector. u_dut uses THRESH=8,
//   u_t1 uses THRESH=1; both share the same stimulus.
module tb_deadlock_block_detector;

  logic        clk;
  logic        reset;
  logic [1:0]  axis;
  logic [9:0]  idle;
  logic [4:0]  blk;
  logic        block;
  logic [4:0]  mask;
  logic [15:0] cnt;
  logic        block1;
  logic [4:0]  mask1;
  logic [15:0] cnt1;

  int unsigned total;
  int unsigned bad;

  localparam logic [9:0] IDLE_ALL = 10'b11_1111_1111;
  localparam logic [9:0] IDLE_C   = 10'b11_1111_1100;

  deadlock_block_detector #(
    .N_AXIS(2), .N_IDLE(10), .N_INST(5), .THRESH(8)
  ) u_dut (
    .clock(clk), .reset(reset), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block), .block_mask(mask), .block_count(cnt)
  );

  deadlock_block_detector #(
    .N_AXIS(2), .N_IDLE(10), .N_INST(5), .THRESH(1)
  ) u_t1 (
    .clock(clk), .reset(reset), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .inst_block_sigs(blk),
    .block(block1), .block_mask(mask1), .block_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cand;
    axis = 2'b00;
    idle = IDLE_C;
    blk  = 5'b00011;
  endtask

  task automatic set_quiet;
    axis = 2'b00;
    idle = IDLE_ALL;
    blk  = 5'b00000;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    set_quiet();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_cand();
    tick();
    tick();
    total++; if (block !== 1'b0) begin bad++; $display("FAIL reset_block got=%b want=0", block); end
    total++; if (mask !== 5'b0) begin bad++; $display("FAIL reset_mask got=%b want=00000", mask); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt); end
    total++; if (block1 !== 1'b0) begin bad++; $display("FAIL reset_block_t1 got=%b want=0", block1); end
    total++; if (cnt1 !== 16'd0) begin bad++; $display("FAIL reset_count_t1 got=%0d want=0", cnt1); end
    reset = 1'b0;
    set_quiet();
  endtask

  task automatic test_all_idle;
    set_quiet();
    for (int i = 0; i < 50; i++) begin
      tick();
      total++; if (block !== 1'b0) begin bad++; $display("FAIL idle_block cyc=%0d got=%b want=0", i, block); end
      total++; if (cnt !== 16'd0) begin bad++; $display("FAIL idle_count cyc=%0d got=%0d want=0", i, cnt); end
    end
  endtask

  task automatic test_detect;
    do_reset();
    set_cand();
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (block !== (k == 8)) begin bad++; $display("FAIL detect_block k=%0d got=%b want=%b", k, block, k == 8); end
      if (k == 1) begin
        total++; if (block1 !== 1'b1) begin bad++; $display("FAIL t1_block got=%b want=1", block1); end
        total++; if (mask1 !== 5'b00011) begin bad++; $display("FAIL t1_mask got=%b want=00011", mask1); end
      end
    end
    total++; if (mask !== 5'b00011) begin bad++; $display("FAIL detect_mask got=%b want=00011", mask); end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL detect_count got=%0d want=1", cnt); end
    set_quiet();
    tick();
    total++; if (block !== 1'b0) begin bad++; $display("FAIL release_block got=%b want=0", block); end
    total++; if (block1 !== 1'b0) begin bad++; $display("FAIL release_block_t1 got=%b want=0", block1); end
    total++; if (mask !== 5'b00011) begin bad++; $display("FAIL release_mask got=%b want=00011", mask); end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL release_count got=%0d want=1", cnt); end
  endtask

  task automatic test_not_stuck;
    do_reset();
    axis = 2'b00;
    idle = IDLE_C;
    blk  = 5'b00001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++; if (block !== 1'b0) begin bad++; $display("FAIL notstuck_block k=%0d got=%b want=0", k, block); end
      total++; if (block1 !== 1'b0) begin bad++; $display("FAIL notstuck_block_t1 k=%0d got=%b want=0", k, block1); end
    end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL notstuck_count got=%0d want=0", cnt); end
  endtask

  task automatic test_axis_pulse;
    do_reset();
    set_cand();
    for (int k = 1; k <= 4; k++) tick();
    axis = 2'b01;
    tick();
    total++; if (block !== 1'b0) begin bad++; $display("FAIL axis_pulse_block got=%b want=0", block); end
    total++; if (block1 !== 1'b0) begin bad++; $display("FAIL axis_pulse_block_t1 got=%b want=0", block1); end
    axis = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (block !== (k == 8)) begin bad++; $display("FAIL axis_after_block k=%0d got=%b want=%b", k, block, k == 8); end
    end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL axis_count got=%0d want=1", cnt); end
  endtask

  task automatic test_drop_restore;
    do_reset();
    set_cand();
    for (int k = 1; k <= 8; k++) tick();
    total++; if (block !== 1'b1) begin bad++; $display("FAIL drop_first_block got=%b want=1", block); end
    set_quiet();
    tick();
    total++; if (block !== 1'b0) begin bad++; $display("FAIL drop_fall_block got=%b want=0", block); end
    set_cand();
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (block !== (k == 8)) begin bad++; $display("FAIL drop_rise_block k=%0d got=%b want=%b", k, block, k == 8); end
    end
    total++; if (cnt !== 16'd2) begin bad++; $display("FAIL drop_count got=%0d want=2", cnt); end
    total++; if (cnt1 !== 16'd2) begin bad++; $display("FAIL drop_count_t1 got=%0d want=2", cnt1); end
  endtask

  task automatic test_mask_hold;
    // still BLOCKED from the previous scenario; grow the stuck set
    axis = 2'b00;
    idle = 10'b11_1111_1000;
    blk  = 5'b00111;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (block !== 1'b1) begin bad++; $display("FAIL hold_block k=%0d got=%b want=1", k, block); end
      total++; if (mask !== 5'b00011) begin bad++; $display("FAIL hold_mask k=%0d got=%b want=00011", k, mask); end
      total++; if (cnt !== 16'd2) begin bad++; $display("FAIL hold_count k=%0d got=%0d want=2", k, cnt); end
    end
  endtask

  task automatic test_all_idle_watch;
    do_reset();
    set_cand();
    for (int k = 1; k <= 5; k++) tick();
    idle = IDLE_ALL;
    blk  = 5'b00011;
    tick();
    total++; if (block !== 1'b0) begin bad++; $display("FAIL allidle_block got=%b want=0", block); end
    total++; if (block1 !== 1'b0) begin bad++; $display("FAIL allidle_block_t1 got=%b want=0", block1); end
    set_cand();
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (block !== (k == 8)) begin bad++; $display("FAIL allidle_after k=%0d got=%b want=%b", k, block, k == 8); end
    end
  endtask

  task automatic test_reset_in_blocked;
    do_reset();
    set_cand();
    for (int k = 1; k <= 8; k++) tick();
    total++; if (block !== 1'b1) begin bad++; $display("FAIL rib_pre_block got=%b want=1", block); end
    reset = 1'b1;
    tick();
    total++; if (block !== 1'b0) begin bad++; $display("FAIL rib_block got=%b want=0", block); end
    total++; if (mask !== 5'b0) begin bad++; $display("FAIL rib_mask got=%b want=00000", mask); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL rib_count got=%0d want=0", cnt); end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (block !== (k == 8)) begin bad++; $display("FAIL rib_redetect k=%0d got=%b want=%b", k, block, k == 8); end
    end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL rib_count_after got=%0d want=1", cnt); end
    total++; if (mask !== 5'b00011) begin bad++; $display("FAIL rib_mask_after got=%b want=00011", mask); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_quiet();
    test_reset();
    test_all_idle();
    test_detect();
    test_not_stuck();
    test_axis_pulse();
    test_drop_restore();
    test_mask_hold();
    test_all_idle_watch();
    test_reset_in_blocked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
